multicycle_control_unit: RTL and testbench

//  Multi-cycle successor to the single-cycle decoder. Sequences each RV32I instruction (optional M ext.)

---
 rtl/multicycle_control_unit.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//   Sequences each RV32I instruction (plus optional M extension) through
//   FETCH / DECODE / EXEC / MEM / WB, with MDU_WAIT for multiply/divide and
//   TRAP for illegal encodings or a memory timeout. Datapath controls are
//   combinational from the current state and the class / alu_ctrl latched in
//   DECODE.
//
// Parameters
//   SUPPORT_M    1: R-type funct7=0000001 is an MDU op; 0: illegal
//   MEM_TIMEOUT  unacked mem_req cycles before a bus-error trap; 0 = never
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   opcode, funct3, funct7          instruction fields from IR (valid after ir_write)
//   branch_taken                    branch comparator result, used in EXEC
//   mem_ack                         memory handshake completion
//   mdu_done                        MDU result valid
//   pc_write, pc_sel                PC update enable / source
//   ir_write                        latch fetched word into IR
//   mem_req, mem_we, mem_is_fetch   memory request controls
//   reg_write, result_src           register-file write enable / source
//   alu_src, alu_src_a, alu_ctrl    ALU operand selects and operation
//   mdu_start, mdu_op               MDU start pulse and operation
//   trap, trap_cause                trap pulse and cause (0 illegal, 1 timeout)
//   state                           current FSM state (debug)
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int SUPPORT_M   = 32'd1,
    parameter int MEM_TIMEOUT = 32'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       branch_taken,
    input  logic       mem_ack,
    input  logic       mdu_done,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_is_fetch,
    output logic       reg_write,
    output logic       alu_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] result_src,
    output logic [3:0] alu_ctrl,
    output logic       mdu_start,
    output logic [2:0] mdu_op,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4,
        S_MDU_WAIT = 3'd5,
        S_TRAP     = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU_R = 4'd0,
        CL_ALU_I = 4'd1,
        CL_LOAD  = 4'd2,
        CL_STORE = 4'd3,
        CL_BR    = 4'd4,
        CL_JAL   = 4'd5,
        CL_JALR  = 4'd6,
        CL_LUI   = 4'd7,
        CL_AUIPC = 4'd8,
        CL_MDU   = 4'd9
    } cls_t;

    // Counter only has to reach MEM_TIMEOUT-1.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t        state_q, state_d;
    cls_t          cls_q, cls_d;
    logic [3:0]    alu_ctrl_q, alu_ctrl_d;
    logic [2:0]    mdu_op_q, mdu_op_d;
    logic          cause_q, cause_d;
    logic [CW-1:0] cnt_q, cnt_d;

    cls_t          dec_cls_s;
    logic [3:0]    dec_alu_s;
    logic          illegal_s;
    logic          expire_s;

    // Expiry fires on the last allowed unacked cycle; an ack in that cycle still wins.
    assign expire_s = (MEM_TIMEOUT > 0) && (cnt_q == CW'(MEM_TIMEOUT - 1));
    assign state    = state_q;

    // Instruction classification, ALU operation and legality from the IR fields.
    always_comb begin
        dec_cls_s = CL_ALU_R;
        dec_alu_s = 4'b0000;
        illegal_s = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    dec_alu_s = {1'b0, funct3};
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec_alu_s = {1'b1, funct3};          // SUB / SRA
                end else if (SUPPORT_M != 0 && funct7 == 7'b0000001) begin
                    dec_cls_s = CL_MDU;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            7'b0010011: begin
                dec_cls_s = CL_ALU_I;
                if (funct3 == 3'b001) begin
                    dec_alu_s = 4'b0001;
                    illegal_s = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    dec_alu_s = {funct7[5], 3'b101};     // SRLI / SRAI
                    illegal_s = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end else begin
                    dec_alu_s = {1'b0, funct3};          // ADDI never subtracts
                end
            end
            7'b0000011: dec_cls_s = CL_LOAD;
            7'b0100011: dec_cls_s = CL_STORE;
            7'b1100011: begin
                dec_cls_s = CL_BR;
                dec_alu_s = 4'b1000;
                illegal_s = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            7'b1101111: dec_cls_s = CL_JAL;
            7'b1100111: dec_cls_s = CL_JALR;
            7'b0110111: dec_cls_s = CL_LUI;
            7'b0010111: dec_cls_s = CL_AUIPC;
            default:    illegal_s = 1'b1;            // includes FENCE and SYSTEM
        endcase
    end

    // Next-state logic and datapath controls.
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        alu_ctrl_d   = alu_ctrl_q;
        mdu_op_d     = mdu_op_q;
        cause_d      = cause_q;
        pc_write     = 1'b0;
        pc_sel       = 2'd0;
        ir_write     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        reg_write    = 1'b0;
        alu_src      = 1'b0;
        alu_src_a    = 2'd0;
        result_src   = 2'd0;
        alu_ctrl     = 4'b0000;
        mdu_start    = 1'b0;
        mdu_op       = 3'b000;
        trap         = 1'b0;
        trap_cause   = 2'd0;
        case (state_q)
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_is_fetch = 1'b1;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (expire_s) begin
                    cause_d = 1'b1;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                cls_d      = dec_cls_s;
                alu_ctrl_d = dec_alu_s;
                mdu_op_d   = funct3;
                if (illegal_s) begin
                    cause_d = 1'b0;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_ctrl = alu_ctrl_q;
                case (cls_q)
                    CL_ALU_I, CL_LOAD, CL_STORE, CL_JALR: alu_src = 1'b1;
                    CL_LUI: begin
                        alu_src   = 1'b1;
                        alu_src_a = 2'd2;
                    end
                    CL_AUIPC, CL_JAL: begin
                        alu_src   = 1'b1;
                        alu_src_a = 2'd1;
                    end
                    default: alu_src = 1'b0;
                endcase
                case (cls_q)
                    CL_BR: begin
                        pc_write = 1'b1;
                        pc_sel   = branch_taken ? 2'd1 : 2'd0;
                        state_d  = S_FETCH;
                    end
                    CL_LOAD, CL_STORE: state_d = S_MEM;
                    CL_MDU: begin
                        mdu_start = 1'b1;
                        mdu_op    = mdu_op_q;
                        state_d   = S_MDU_WAIT;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls_q == CL_STORE);
                if (mem_ack) begin
                    if (cls_q == CL_STORE) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_WB;
                    end
                end else if (expire_s) begin
                    cause_d = 1'b1;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_MDU_WAIT: begin
                if (mdu_done) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_MDU_WAIT;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                case (cls_q)
                    CL_LOAD: result_src = 2'd1;
                    CL_JAL: begin
                        result_src = 2'd2;
                        pc_sel     = 2'd1;
                    end
                    CL_JALR: begin
                        result_src = 2'd2;
                        pc_sel     = 2'd2;
                    end
                    CL_MDU:  result_src = 2'd3;
                    default: result_src = 2'd0;
                endcase
                state_d = S_FETCH;
            end
            S_TRAP: begin
                trap       = 1'b1;
                trap_cause = {1'b0, cause_q};
                pc_write   = 1'b1;
                pc_sel     = 2'd3;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Timeout counter: runs while waiting in FETCH/MEM, zero on any state change.
    always_comb begin
        if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // State and decode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            cls_q      <= CL_ALU_R;
            alu_ctrl_q <= 4'b0000;
            mdu_op_q   <= 3'b000;
            cause_q    <= 1'b0;
            cnt_q      <= {CW{1'b0}};
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            alu_ctrl_q <= alu_ctrl_d;
            mdu_op_q   <= mdu_op_d;
            cause_q    <= cause_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//   Two instances: u0 (SUPPORT_M=1, MEM_TIMEOUT=8) and u1 (SUPPORT_M=0,
//   MEM_TIMEOUT=0). Only one runs at a time; the other is held in reset.
//   Each instruction is turned by the reference model into its sequence of
//   phases, and every cycle's full output vector is compared.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n        [2];
    logic [6:0] opcode       [2];
    logic [2:0] funct3       [2];
    logic [6:0] funct7       [2];
    logic       branch_taken [2];
    logic       mem_ack      [2];
    logic       mdu_done     [2];
    logic       pc_write     [2];
    logic [1:0] pc_sel       [2];
    logic       ir_write     [2];
    logic       mem_req      [2];
    logic       mem_we       [2];
    logic       mem_is_fetch [2];
    logic       reg_write    [2];
    logic       alu_src      [2];
    logic [1:0] alu_src_a    [2];
    logic [1:0] result_src   [2];
    logic [3:0] alu_ctrl     [2];
    logic       mdu_start    [2];
    logic [2:0] mdu_op       [2];
    logic       trap         [2];
    logic [1:0] trap_cause   [2];
    logic [2:0] state        [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        multicycle_control_unit #(
            .SUPPORT_M  ((g == 0) ? 1 : 0),
            .MEM_TIMEOUT((g == 0) ? 8 : 0)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n[g]),
            .opcode      (opcode[g]),
            .funct3      (funct3[g]),
            .funct7      (funct7[g]),
            .branch_taken(branch_taken[g]),
            .mem_ack     (mem_ack[g]),
            .mdu_done    (mdu_done[g]),
            .pc_write    (pc_write[g]),
            .pc_sel      (pc_sel[g]),
            .ir_write    (ir_write[g]),
            .mem_req     (mem_req[g]),
            .mem_we      (mem_we[g]),
            .mem_is_fetch(mem_is_fetch[g]),
            .reg_write   (reg_write[g]),
            .alu_src     (alu_src[g]),
            .alu_src_a   (alu_src_a[g]),
            .result_src  (result_src[g]),
            .alu_ctrl    (alu_ctrl[g]),
            .mdu_start   (mdu_start[g]),
            .mdu_op      (mdu_op[g]),
            .trap        (trap[g]),
            .trap_cause  (trap_cause[g]),
            .state       (state[g])
        );
    end

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       mreq;
        logic       mwe;
        logic       mif;
        logic       rw;
        logic       asrc;
        logic [1:0] asa;
        logic [1:0] rs;
        logic [3:0] actl;
        logic       ms;
        logic [2:0] mop;
        logic       tr;
        logic [1:0] tc;
    } obs_t;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUI = 8, K_MDU = 9;
    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, SLL = 4'b0001, SLT = 4'b0010;
    localparam logic [3:0] SLTU = 4'b0011, XOR = 4'b0100, SRL = 4'b0101, SRA = 4'b1101;
    localparam logic [3:0] OR = 4'b0110, AND = 4'b0111;

    int n_cmp = 0;
    int n_bad = 0;
    int inum  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic obs_t observe(input int u);
        obs_t o;
        o.st   = state[u];
        o.pcw  = pc_write[u];
        o.pcs  = pc_sel[u];
        o.irw  = ir_write[u];
        o.mreq = mem_req[u];
        o.mwe  = mem_we[u];
        o.mif  = mem_is_fetch[u];
        o.rw   = reg_write[u];
        o.asrc = alu_src[u];
        o.asa  = alu_src_a[u];
        o.rs   = result_src[u];
        o.actl = alu_ctrl[u];
        o.ms   = mdu_start[u];
        o.mop  = mdu_op[u];
        o.tr   = trap[u];
        o.tc   = trap_cause[u];
        return o;
    endfunction

    // Reference decode: class, legality and ALU mnemonic from the instruction rules.
    function automatic void classify(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                     input bit sm, output int k, output bit ill, output logic [3:0] ac);
        logic [3:0] tbl [8];
        tbl = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
        k   = K_R;
        ill = 1'b0;
        ac  = ADD;
        case (op)
            7'h33: begin
                if (f7 == 7'h00) ac = tbl[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) ac = SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) ac = SRA;
                else if (sm && f7 == 7'h01) k = K_MDU;
                else ill = 1'b1;
            end
            7'h13: begin
                k  = K_I;
                ac = tbl[f3];
                if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) ac = SRA;
                    else if (f7 != 7'h00) ill = 1'b1;
                end
            end
            7'h03: k = K_LD;
            7'h23: k = K_ST;
            7'h63: begin
                k   = K_BR;
                ac  = SUB;
                ill = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'h6F: k = K_JAL;
            7'h67: k = K_JALR;
            7'h37: k = K_LUI;
            7'h17: k = K_AUI;
            default: ill = 1'b1;
        endcase
    endfunction

    // One clock cycle: drive inputs at the falling edge, compare outputs just after.
    task automatic cycle(input int u, input logic ack, input logic tk, input logic done,
                         input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input obs_t e, input string name);
        @(negedge clk);
        rst_n[u]        = 1'b1;
        mem_ack[u]      = ack;
        branch_taken[u] = tk;
        mdu_done[u]     = done;
        opcode[u]       = op;
        funct3[u]       = f3;
        funct7[u]       = f7;
        #1;
        check_val($sformatf("u%0d i%0d %s", u, inum, name), {5'd0, observe(u)}, {5'd0, e});
    endtask

    task automatic trap_cycle(input int u, input logic [1:0] cause, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7);
        obs_t e;
        e     = '0;
        e.st  = 3'd6;
        e.tr  = 1'b1;
        e.tc  = cause;
        e.pcw = 1'b1;
        e.pcs = 2'd3;
        cycle(u, 1'($urandom), 1'($urandom), 1'($urandom), op, f3, f7, e, "trap");
    endtask

    // fw/mw: unacked cycles before ack; dw: MDU_WAIT cycles before done; rst_mem: MEM cycle to reset at (-1 none).
    task automatic run_instr(input int u, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int fw, input int mw, input logic tk, input int dw, input int rst_mem);
        int         to;
        int         k;
        bit         ill;
        bit         trapped;
        logic [3:0] ac;
        obs_t       e;
        to      = (u == 0) ? 8 : 0;
        trapped = 1'b0;
        inum++;
        classify(op, f3, f7, (u == 0), k, ill, ac);

        for (int w = 0; w <= fw; w++) begin
            logic ack;
            ack   = (w == fw);
            e     = '0;
            e.mreq = 1'b1;
            e.mif  = 1'b1;
            e.irw  = ack;
            cycle(u, ack, 1'($urandom), 1'($urandom), 7'($urandom), 3'($urandom), 7'($urandom), e, "fetch");
            if (!ack && to > 0 && w == to - 1) begin
                trapped = 1'b1;
                break;
            end
        end
        if (trapped) begin
            trap_cycle(u, 2'd1, op, f3, f7);
            return;
        end

        e    = '0;
        e.st = 3'd1;
        cycle(u, 1'($urandom), 1'($urandom), 1'($urandom), op, f3, f7, e, "decode");
        if (ill) begin
            trap_cycle(u, 2'd0, op, f3, f7);
            return;
        end

        e      = '0;
        e.st   = 3'd2;
        e.actl = ac;
        e.asrc = (k == K_I || k == K_LD || k == K_ST || k == K_JALR || k == K_LUI || k == K_AUI || k == K_JAL);
        e.asa  = (k == K_LUI) ? 2'd2 : ((k == K_AUI || k == K_JAL) ? 2'd1 : 2'd0);
        if (k == K_BR) begin
            e.pcw = 1'b1;
            e.pcs = tk ? 2'd1 : 2'd0;
        end
        if (k == K_MDU) begin
            e.ms  = 1'b1;
            e.mop = f3;
        end
        cycle(u, 1'($urandom), tk, 1'($urandom), op, f3, f7, e, "exec");
        if (k == K_BR) return;

        if (k == K_LD || k == K_ST) begin
            for (int w = 0; w <= mw; w++) begin
                logic ack;
                if (w == rst_mem) begin
                    @(negedge clk);
                    rst_n[u]   = 1'b0;
                    mem_ack[u] = 1'b0;
                    #1;
                    e      = '0;
                    e.mreq = 1'b1;
                    e.mif  = 1'b1;
                    check_val($sformatf("u%0d i%0d reset-mid-mem", u, inum), {5'd0, observe(u)}, {5'd0, e});
                    return;
                end
                ack    = (w == mw);
                e      = '0;
                e.st   = 3'd3;
                e.mreq = 1'b1;
                e.mwe  = (k == K_ST);
                e.pcw  = ack && (k == K_ST);
                cycle(u, ack, 1'($urandom), 1'($urandom), op, f3, f7, e, "mem");
                if (!ack && to > 0 && w == to - 1) begin
                    trapped = 1'b1;
                    break;
                end
            end
            if (trapped) begin
                trap_cycle(u, 2'd1, op, f3, f7);
                return;
            end
            if (k == K_ST) return;
        end

        if (k == K_MDU) begin
            for (int w = 0; w <= dw; w++) begin
                e    = '0;
                e.st = 3'd5;
                cycle(u, 1'($urandom), 1'($urandom), (w == dw), op, f3, f7, e, "mdu-wait");
            end
        end

        e     = '0;
        e.st  = 3'd4;
        e.rw  = 1'b1;
        e.pcw = 1'b1;
        e.rs  = (k == K_LD) ? 2'd1 : ((k == K_JAL || k == K_JALR) ? 2'd2 : ((k == K_MDU) ? 2'd3 : 2'd0));
        e.pcs = (k == K_JAL) ? 2'd1 : ((k == K_JALR) ? 2'd2 : 2'd0);
        cycle(u, 1'($urandom), 1'($urandom), 1'($urandom), op, f3, f7, e, "wb");
    endtask

    task automatic random_instr(input int u);
        logic [6:0] ops [12];
        logic [6:0] op;
        logic [6:0] f7;
        int         fw, mw, sel, rm;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h00};
        sel = $urandom_range(0, 11);
        op  = (sel == 11) ? 7'($urandom) : ops[sel];
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        fw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 11) : $urandom_range(0, 3);
        mw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 11) : $urandom_range(0, 3);
        rm = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : -1;
        run_instr(u, op, 3'($urandom), f7, fw, mw, 1'($urandom), $urandom_range(0, 6), rm);
    endtask

    initial begin
        obs_t e;
        for (int i = 0; i < 2; i++) begin
            rst_n[i]        = 1'b0;
            opcode[i]       = 7'h00;
            funct3[i]       = 3'd0;
            funct7[i]       = 7'h00;
            branch_taken[i] = 1'b0;
            mem_ack[i]      = 1'b0;
            mdu_done[i]     = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1;
        e      = '0;
        e.mreq = 1'b1;
        e.mif  = 1'b1;
        check_val("u0 reset", {5'd0, observe(0)}, {5'd0, e});
        check_val("u1 reset", {5'd0, observe(1)}, {5'd0, e});

        // Instance 0: SUPPORT_M=1, MEM_TIMEOUT=8
        run_instr(0, 7'h33, 3'd0, 7'h00, 0, 0, 1'b0, 0, -1);   // ADD x3,x1,x2
        run_instr(0, 7'h03, 3'd2, 7'h00, 0, 3, 1'b0, 0, -1);   // LW, ack 3 cycles late
        run_instr(0, 7'h63, 3'd0, 7'h00, 0, 0, 1'b1, 0, -1);   // BEQ taken
        run_instr(0, 7'h63, 3'd0, 7'h00, 0, 0, 1'b0, 0, -1);   // BEQ not taken
        run_instr(0, 7'h7F, 3'd0, 7'h00, 0, 0, 1'b0, 0, -1);   // unknown opcode
        run_instr(0, 7'h33, 3'd4, 7'h01, 0, 0, 1'b0, 5, -1);   // DIV, done 6 cycles after start
        run_instr(0, 7'h33, 3'd0, 7'h00, 20, 0, 1'b0, 0, -1);  // fetch timeout
        run_instr(0, 7'h33, 3'd5, 7'h20, 7, 0, 1'b0, 0, -1);   // SRA, ack on expiry cycle
        run_instr(0, 7'h03, 3'd2, 7'h00, 0, 20, 1'b0, 0, -1);  // load timeout in MEM
        run_instr(0, 7'h23, 3'd2, 7'h00, 0, 7, 1'b0, 0, -1);   // store, ack on expiry cycle
        run_instr(0, 7'h03, 3'd2, 7'h00, 0, 5, 1'b0, 0, 2);    // reset mid-MEM
        run_instr(0, 7'h13, 3'd5, 7'h20, 0, 0, 1'b0, 0, -1);   // SRAI
        run_instr(0, 7'h13, 3'd1, 7'h20, 0, 0, 1'b0, 0, -1);   // SLLI bad funct7
        run_instr(0, 7'h6F, 3'd0, 7'h00, 1, 0, 1'b0, 0, -1);   // JAL
        run_instr(0, 7'h67, 3'd0, 7'h00, 0, 0, 1'b0, 0, -1);   // JALR
        run_instr(0, 7'h37, 3'd0, 7'h00, 0, 0, 1'b0, 0, -1);   // LUI
        run_instr(0, 7'h17, 3'd0, 7'h00, 0, 0, 1'b0, 0, -1);   // AUIPC
        run_instr(0, 7'h63, 3'd2, 7'h00, 0, 0, 1'b0, 0, -1);   // branch f3=010
        run_instr(0, 7'h0F, 3'd0, 7'h00, 0, 0, 1'b0, 0, -1);   // FENCE
        run_instr(0, 7'h73, 3'd0, 7'h00, 0, 0, 1'b0, 0, -1);   // SYSTEM
        for (int i = 0; i < 60; i++) random_instr(0);

        // Instance 1: SUPPORT_M=0, MEM_TIMEOUT=0
        @(negedge clk);
        rst_n[0] = 1'b0;
        run_instr(1, 7'h33, 3'd0, 7'h01, 0, 0, 1'b0, 0, -1);   // MUL is illegal here
        run_instr(1, 7'h33, 3'd0, 7'h20, 12, 0, 1'b0, 0, -1);  // SUB, long fetch wait, no timeout
        run_instr(1, 7'h03, 3'd0, 7'h00, 0, 12, 1'b0, 0, -1);  // LB, long MEM wait
        for (int i = 0; i < 60; i++) random_instr(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
